// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the default protection attribute.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out, min 3 cycles cmd->rsp.
// Backpressure: CMD_READY is low until the previous response is consumed; all AXI outputs are registered.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              A_CLK,
  input  logic              A_RSTn,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  input  logic [STRB_W-1:0] CMD_WSTRB,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_WRITE,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic [1:0]        RSP_RESP,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic [2:0]        AW_PROT,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic [STRB_W-1:0] W_STRB,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP,
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [ADDR_W-1:0] AR_ADDR,
  output logic [2:0]        AR_PROT,
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA
  } state_e;

  state_e            state_q;
  logic              cmd_rdy_q;
  logic              aw_vld_q, w_vld_q, ar_vld_q, b_rdy_q, r_rdy_q;
  logic              aw_done_q, w_done_q;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              rsp_vld_q, rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  axi_resp_e         rsp_resp_q;

  logic aw_hs, w_hs;
  assign aw_hs = aw_vld_q && AW_READY;
  assign w_hs  = w_vld_q && W_READY;

  always_ff @(posedge A_CLK) begin
    if (!A_RSTn) begin
      state_q     <= S_IDLE;
      cmd_rdy_q   <= 1'b0;
      aw_vld_q    <= 1'b0;
      w_vld_q     <= 1'b0;
      ar_vld_q    <= 1'b0;
      b_rdy_q     <= 1'b0;
      r_rdy_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          // CMD_READY is registered so it is also 0 on the first cycle out of reset.
          if (rsp_vld_q && RSP_READY) begin
            rsp_vld_q <= 1'b0;
            cmd_rdy_q <= 1'b1;
          end else if (cmd_rdy_q && CMD_VALID) begin
            cmd_rdy_q <= 1'b0;
            if (CMD_WRITE) begin
              aw_addr_q <= CMD_ADDR;
              w_data_q  <= CMD_WDATA;
              w_strb_q  <= CMD_WSTRB;
              aw_vld_q  <= 1'b1;
              w_vld_q   <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR_REQ;
            end else begin
              ar_addr_q <= CMD_ADDR;
              ar_vld_q  <= 1'b1;
              state_q   <= S_RD_REQ;
            end
          end else if (!rsp_vld_q) begin
            cmd_rdy_q <= 1'b1;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) begin
            aw_vld_q  <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            w_vld_q  <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            b_rdy_q <= 1'b1;
            state_q <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (B_VALID) begin
            b_rdy_q     <= 1'b0;
            rsp_vld_q   <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= axi_resp_e'(B_RESP);
            state_q     <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (AR_READY) begin
            ar_vld_q <= 1'b0;
            r_rdy_q  <= 1'b1;
            state_q  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (R_VALID) begin
            r_rdy_q     <= 1'b0;
            rsp_vld_q   <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= R_DATA;
            rsp_resp_q  <= axi_resp_e'(R_RESP);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CMD_READY = cmd_rdy_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_WRITE = rsp_write_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;
  assign AW_VALID  = aw_vld_q;
  assign AW_ADDR   = aw_addr_q;
  assign AW_PROT   = AXI_PROT_DEFAULT;
  assign W_VALID   = w_vld_q;
  assign W_DATA    = w_data_q;
  assign W_STRB    = w_strb_q;
  assign B_READY   = b_rdy_q;
  assign AR_VALID  = ar_vld_q;
  assign AR_ADDR   = ar_addr_q;
  assign AR_PROT   = AXI_PROT_DEFAULT;
  assign R_READY   = r_rdy_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master; inputs change and outputs are sampled on the falling edge.
module tb_axi4lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [2:0]  aw_prot, ar_prot;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi4lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .A_CLK(clk), .A_RSTn(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_WRITE(rsp_write),
    .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
    .AW_VALID(aw_valid), .AW_READY(aw_ready), .AW_ADDR(aw_addr), .AW_PROT(aw_prot),
    .W_VALID(w_valid), .W_READY(w_ready), .W_DATA(w_data), .W_STRB(w_strb),
    .B_VALID(b_valid), .B_READY(b_ready), .B_RESP(b_resp),
    .AR_VALID(ar_valid), .AR_READY(ar_ready), .AR_ADDR(ar_addr), .AR_PROT(ar_prot),
    .R_VALID(r_valid), .R_READY(r_ready), .R_DATA(r_data), .R_RESP(r_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {aw_valid, w_valid, ar_valid, rsp_valid}, 0);
    chk("rst_readys", {b_ready, r_ready}, 0);
    chk("rst_payload", {aw_addr, w_data}, 0);
    chk("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 0);
    chk("rst_prot", {aw_prot, ar_prot}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Write, zero-wait slave
    aw_ready = 1'b1; w_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    chk("w1_c1_valids", {aw_valid, w_valid}, 2'b11);
    chk("w1_c1_aw_addr", aw_addr, 32'h0000_0010);
    chk("w1_c1_w_data", w_data, 32'hDEAD_BEEF);
    chk("w1_c1_w_strb", w_strb, 4'hF);
    chk("w1_c1_cmd_ready", cmd_ready, 0);
    step();
    chk("w1_c2_valids", {aw_valid, w_valid}, 2'b00);
    chk("w1_c2_b_ready", b_ready, 1);
    b_valid = 1'b1; b_resp = 2'b00;
    step();
    b_valid = 1'b0;
    chk("w1_c3_rsp_valid", rsp_valid, 1);
    chk("w1_c3_rsp", {rsp_write, rsp_rdata, rsp_resp}, {1'b1, 32'h0, 2'b00});
    chk("w1_c3_b_ready", b_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w1_c4_rsp_valid", rsp_valid, 0);
    chk("w1_c4_cmd_ready", cmd_ready, 1);

    // Write, W_READY 3 cycles after AW_READY
    aw_ready = 1'b1; w_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0020; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'h3;
    step();
    cmd_valid = 1'b0;
    chk("w2_c1_valids", {aw_valid, w_valid}, 2'b11);
    step();
    chk("w2_c2_valids", {aw_valid, w_valid}, 2'b01);
    chk("w2_c2_b_ready", b_ready, 0);
    step();
    chk("w2_c3_valids", {aw_valid, w_valid, w_data}, {2'b01, 32'hCAFE_F00D});
    step();
    chk("w2_c4_valids", {aw_valid, w_valid, w_strb}, {2'b01, 4'h3});
    w_ready = 1'b1;
    step();
    chk("w2_c5_valids", {aw_valid, w_valid}, 2'b00);
    chk("w2_c5_b_ready", b_ready, 1);
    b_valid = 1'b1; b_resp = 2'b01;
    step();
    b_valid = 1'b0;
    chk("w2_c6_rsp", {rsp_valid, rsp_write, rsp_resp}, {2'b11, 2'b01});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w2_c7_rsp_valid", rsp_valid, 0);
    step();
    chk("w2_c8_single_rsp", {rsp_valid, cmd_ready}, 2'b01);

    // Read with SLVERR
    ar_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0004;
    step();
    cmd_valid = 1'b0;
    chk("r_c1_valids", {ar_valid, aw_valid, w_valid}, 3'b100);
    chk("r_c1_ar_addr", ar_addr, 32'h0000_0004);
    step();
    chk("r_c2_ar_valid", ar_valid, 0);
    chk("r_c2_r_ready", r_ready, 1);
    r_valid = 1'b1; r_data = 32'h1234_5678; r_resp = 2'b10;
    step();
    r_valid = 1'b0;
    chk("r_c3_rsp", {rsp_valid, rsp_write, rsp_resp}, {2'b10, 2'b10});
    chk("r_c3_rdata", rsp_rdata, 32'h1234_5678);
    chk("r_c3_r_ready", r_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r_c4_rsp_valid", rsp_valid, 0);

    // Early B_VALID, then RSP_READY held low 5 cycles
    aw_ready = 1'b1; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b11;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0030; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'h0;
    step();
    cmd_valid = 1'b0;
    chk("eb_c1_b_ready", b_ready, 0);
    step();
    chk("eb_c2_b_ready", {b_ready, w_valid, rsp_valid}, 3'b010);
    step();
    chk("eb_c3_b_ready", {b_ready, w_valid, rsp_valid}, 3'b010);
    w_ready = 1'b1;
    step();
    chk("eb_c4_b_ready", {b_ready, w_valid}, 2'b10);
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {2'b11, 32'h0, 2'b11});
      chk("hold_cmd_ready", cmd_ready, 0);
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hold_release", {rsp_valid, cmd_ready}, 2'b01);

    // Reset during WR_REQ
    aw_ready = 1'b0; w_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0040; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hA;
    step();
    cmd_valid = 1'b0;
    chk("rw_c1_valids", {aw_valid, w_valid}, 2'b11);
    rst_n = 1'b0;
    step();
    chk("rw_rst_valids", {aw_valid, w_valid, b_ready, cmd_ready, rsp_valid}, 0);
    chk("rw_rst_payload", {aw_addr, w_data, w_strb}, 0);
    rst_n = 1'b1;
    step();
    chk("rw_idle_cmd_ready", cmd_ready, 1);
    aw_ready = 1'b1; w_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0044; cmd_wdata = 32'h0F0F_0F0F; cmd_wstrb = 4'h5;
    step();
    cmd_valid = 1'b0;
    chk("rw2_c1", {aw_valid, w_valid, aw_addr, w_data}, {2'b11, 32'h0000_0044, 32'h0F0F_0F0F});
    step();
    chk("rw2_c2_b_ready", b_ready, 1);
    b_valid = 1'b1; b_resp = 2'b10;
    step();
    b_valid = 1'b0;
    chk("rw2_c3_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {2'b11, 32'h0, 2'b10});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rw2_c4_done", {rsp_valid, cmd_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
